// File: rtl/zxio_pkg.sv
// Shared types and constants for the Z80-style I/O bus initiator.
// States are IDLE, T1, T2, TW and T3; the value returned for an undriven bus is also defined here.
package zxio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3
  } zxio_state_e;

  localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

  // Width of the in-T-state clock counter; never narrower than one bit.
  function automatic int tcnt_width(input int clk_per_t);
    return (clk_per_t <= 2) ? 1 : $clog2(clk_per_t);
  endfunction

endpackage

// File: rtl/zxio_tstate_timer.sv
// Counts system clocks inside one T-state and flags the last one.
// Wrapping on t_last restarts the count each time a new T-state begins.
module zxio_tstate_timer
  import zxio_pkg::*;
#(
  parameter int CLK_PER_T = 8,
  parameter int CNT_W     = tcnt_width(CLK_PER_T)
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic t_last
);

  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(CLK_PER_T - 1);

  logic [CNT_W-1:0] tcnt;

  assign t_last = run && (tcnt == TCNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (!run || t_last) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/zxio_bus_initiator.sv
// Z80-style I/O bus master: turns one request into a timed IN/OUT cycle
// (T1, T2, TW..., T3) on a/iorq_n/rd_n/wr_n and reports the result.
module zxio_bus_initiator
  import zxio_pkg::*;
#(
  parameter int CLK_PER_T   = 8,
  parameter int WAIT_STATES = 1,
  parameter int MAX_WAIT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [15:0] a,
  output logic [7:0]  dout,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  input  logic [7:0]  din,
  input  logic        oe_in,
  input  logic        wait_n
);

  localparam logic [1:0] AUTO_TW   = 2'(WAIT_STATES);
  localparam logic [7:0] MAX_EXTRA = 8'(MAX_WAIT);

  zxio_state_e state, state_nxt;
  logic        t_last;
  logic        accept;
  logic        cycle_end;
  logic        strobe_nxt;
  logic        wr_q;
  logic [1:0]  auto_cnt, auto_cnt_nxt;
  logic [7:0]  extra_cnt, extra_cnt_nxt;
  logic        abort_q, abort_nxt;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign cycle_end = (state == T3) && t_last;

  zxio_tstate_timer #(
    .CLK_PER_T (CLK_PER_T)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state != IDLE),
    .t_last (t_last)
  );

  always_comb begin
    state_nxt     = state;
    auto_cnt_nxt  = auto_cnt;
    extra_cnt_nxt = extra_cnt;
    abort_nxt     = abort_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt     = T1;
          auto_cnt_nxt  = '0;
          extra_cnt_nxt = '0;
          abort_nxt     = 1'b0;
        end
      end
      T1: if (t_last) state_nxt = T2;
      // Automatic TWs run first; wait_n only matters once they are used up.
      T2, TW: begin
        if (t_last) begin
          if (auto_cnt != AUTO_TW) begin
            state_nxt    = TW;
            auto_cnt_nxt = auto_cnt + 2'd1;
          end else if (!wait_n) begin
            if (extra_cnt == MAX_EXTRA) begin
              state_nxt = T3;
              abort_nxt = 1'b1;
            end else begin
              state_nxt     = TW;
              extra_cnt_nxt = extra_cnt + 8'd1;
            end
          end else begin
            state_nxt = T3;
          end
        end
      end
      T3: if (t_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    strobe_nxt = 1'b0;
    if (state_nxt == T2 || state_nxt == TW || state_nxt == T3) strobe_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      auto_cnt  <= '0;
      extra_cnt <= '0;
      abort_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      auto_cnt  <= auto_cnt_nxt;
      extra_cnt <= extra_cnt_nxt;
      abort_q   <= abort_nxt;
    end
  end

  // Bus pins are registered so the strobes are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      a      <= '0;
      dout   <= '0;
      iorq_n <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
    end else begin
      iorq_n <= !strobe_nxt;
      rd_n   <= !(strobe_nxt && !wr_q);
      wr_n   <= !(strobe_nxt && wr_q);
      if (accept) begin
        wr_q <= req_write;
        a    <= req_addr;
        dout <= req_write ? req_wdata : 8'h00;
      end else if (cycle_end) begin
        a    <= '0;
        dout <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= BUS_IDLE_DATA;
    end else begin
      rsp_valid   <= cycle_end;
      rsp_timeout <= cycle_end && abort_q;
      if (cycle_end && !wr_q) begin
        rsp_rdata <= (abort_q || !oe_in) ? BUS_IDLE_DATA : din;
      end
    end
  end

endmodule

// File: tb/tb_zxio_bus_initiator.sv
// Directed bench for zxio_bus_initiator with CLK_PER_T=4, WAIT_STATES=1, MAX_WAIT=4.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_zxio_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [15:0] a;
  logic [7:0]  dout, din;
  logic        iorq_n, rd_n, wr_n, oe_in, wait_n;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  zxio_bus_initiator #(
    .CLK_PER_T   (4),
    .WAIT_STATES (1),
    .MAX_WAIT    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .a           (a),
    .dout        (dout),
    .iorq_n      (iorq_n),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .din         (din),
    .oe_in       (oe_in),
    .wait_n      (wait_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge with the DUT idle. Returns on the falling edge where
  // rsp_valid is seen. The responder holds wait_n low for nwait sample points
  // (strobe clocks 8, 12, 16, ...) and drives dv with oe_in while rd_n is low if drv.
  task automatic run_cycle(input logic wr, input logic [15:0] ad, input logic [7:0] wd,
                           input int nwait, input logic drv, input logic [7:0] dv,
                           output int lat, output int n_io, output int n_rd, output int n_wr,
                           output logic [15:0] a_s, output logic [7:0] dout_s, output logic rdy1);
    int c;
    bit done;
    c = 0; done = 0; lat = -1;
    n_io = 0; n_rd = 0; n_wr = 0;
    a_s = '0; dout_s = '0; rdy1 = 1'b1;
    req_write = wr; req_addr = ad; req_wdata = wd; req_valid = 1'b1;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        req_valid = 1'b0;
        a_s = a; dout_s = dout; rdy1 = req_ready;
      end
      if (!iorq_n) n_io++;
      if (!rd_n)   n_rd++;
      if (!wr_n)   n_wr++;
      wait_n = !(nwait > 0 && !iorq_n && n_io <= 4 + 4 * nwait);
      oe_in  = drv && !rd_n;
      din    = (drv && !rd_n) ? dv : 8'h00;
      if (rsp_valid) begin
        lat = c;
        done = 1;
      end
    end
    if (!done) check_eq("cycle_timeout", 32'(c), 32'd0);
    wait_n = 1'b1; oe_in = 1'b0; din = 8'h00;
  endtask

  int lat, n_io, n_rd, n_wr, cnt;
  logic [15:0] a_s;
  logic [7:0]  dout_s;
  logic        rdy1;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    din = 8'h00; oe_in = 1'b0; wait_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'hFF);
    check_eq("rst_bus", {a, dout, 5'd0, iorq_n, rd_n, wr_n}, {16'h0000, 8'h00, 8'h07});

    // Write 0x5A to 0x2FFD.
    run_cycle(1'b1, 16'h2FFD, 8'h5A, 0, 1'b0, 8'h00, lat, n_io, n_rd, n_wr, a_s, dout_s, rdy1);
    check_eq("wr_addr", 32'(a_s), 32'h2FFD);
    check_eq("wr_dout", 32'(dout_s), 32'h5A);
    check_eq("wr_busy", 32'(rdy1), 32'd0);
    check_eq("wr_iorq_w", 32'(n_io), 32'd12);
    check_eq("wr_wr_w", 32'(n_wr), 32'd12);
    check_eq("wr_rd_w", 32'(n_rd), 32'd0);
    check_eq("wr_lat", 32'(lat), 32'd17);
    check_eq("wr_tmo", 32'(rsp_timeout), 32'd0);
    check_eq("wr_rdata", 32'(rsp_rdata), 32'hFF);
    check_eq("wr_bus_idle", {a, dout, 5'd0, iorq_n, rd_n, wr_n}, {16'h0000, 8'h00, 8'h07});

    // Read 0x3FFD with nobody driving.
    run_cycle(1'b0, 16'h3FFD, 8'h00, 0, 1'b0, 8'h00, lat, n_io, n_rd, n_wr, a_s, dout_s, rdy1);
    check_eq("rd_float_data", 32'(rsp_rdata), 32'hFF);
    check_eq("rd_float_lat", 32'(lat), 32'd17);
    check_eq("rd_float_dout", 32'(dout_s), 32'h00);

    // Read 0x00FE, responder drives 0x3C.
    run_cycle(1'b0, 16'h00FE, 8'h00, 0, 1'b1, 8'h3C, lat, n_io, n_rd, n_wr, a_s, dout_s, rdy1);
    check_eq("rd_ula_addr", 32'(a_s), 32'h00FE);
    check_eq("rd_ula_data", 32'(rsp_rdata), 32'h3C);
    check_eq("rd_ula_rd_w", 32'(n_rd), 32'd12);
    check_eq("rd_ula_wr_w", 32'(n_wr), 32'd0);

    // A write must leave the last read data alone.
    run_cycle(1'b1, 16'h1234, 8'hC3, 0, 1'b0, 8'h00, lat, n_io, n_rd, n_wr, a_s, dout_s, rdy1);
    check_eq("wr_keeps_rdata", 32'(rsp_rdata), 32'h3C);

    // Three low wait samples stretch the strobe to 24 clocks.
    run_cycle(1'b0, 16'h2FFD, 8'h00, 3, 1'b1, 8'hA5, lat, n_io, n_rd, n_wr, a_s, dout_s, rdy1);
    check_eq("wait_iorq_w", 32'(n_io), 32'd24);
    check_eq("wait_rd_w", 32'(n_rd), 32'd24);
    check_eq("wait_lat", 32'(lat), 32'd29);
    check_eq("wait_data", 32'(rsp_rdata), 32'hA5);
    check_eq("wait_tmo", 32'(rsp_timeout), 32'd0);

    // wait_n stuck low: 4 extra TWs then abort; driven data is discarded.
    run_cycle(1'b0, 16'h3FFD, 8'h00, 1000, 1'b1, 8'h77, lat, n_io, n_rd, n_wr, a_s, dout_s, rdy1);
    check_eq("abort_iorq_w", 32'(n_io), 32'd28);
    check_eq("abort_lat", 32'(lat), 32'd33);
    check_eq("abort_tmo", 32'(rsp_timeout), 32'd1);
    check_eq("abort_data", 32'(rsp_rdata), 32'hFF);
    @(negedge clk);
    check_eq("abort_tmo_pulse", 32'(rsp_timeout), 32'd0);

    run_cycle(1'b0, 16'h00FE, 8'h00, 0, 1'b1, 8'h11, lat, n_io, n_rd, n_wr, a_s, dout_s, rdy1);
    check_eq("post_abort_data", 32'(rsp_rdata), 32'h11);
    check_eq("post_abort_tmo", 32'(rsp_timeout), 32'd0);
    check_eq("post_abort_lat", 32'(lat), 32'd17);

    // Reset in the automatic TW of a write.
    req_write = 1'b1; req_addr = 16'h4321; req_wdata = 8'hE7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("rst_mid_pre_wr", {iorq_n, wr_n}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_mid_strobes", {a, 5'd0, iorq_n, rd_n, wr_n}, {16'h0000, 8'h07});
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check_eq("rst_mid_no_rsp", 32'(cnt), 32'd0);
    run_cycle(1'b0, 16'h00FE, 8'h00, 0, 1'b1, 8'h96, lat, n_io, n_rd, n_wr, a_s, dout_s, rdy1);
    check_eq("rst_mid_next_data", 32'(rsp_rdata), 32'h96);
    check_eq("rst_mid_next_lat", 32'(lat), 32'd17);

    // Back-to-back with req_valid held; second request fields are presented during the first cycle.
    req_write = 1'b1; req_addr = 16'h00FE; req_wdata = 8'h07; req_valid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        req_write = 1'b0; req_addr = 16'h3FFD; req_wdata = 8'h00;
      end
      if (cnt == 6) check_eq("b2b_first_addr", 32'(a), 32'h00FE);
    end while (!rsp_valid && cnt < 200);
    check_eq("b2b_first_lat", 32'(cnt), 32'd17);
    check_eq("b2b_ready_at_rsp", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("b2b_second_t1", {15'd0, req_ready, a}, {16'd0, 16'h3FFD});
    cnt = 1;
    while (!rsp_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("b2b_second_lat", 32'(cnt), 32'd17);
    check_eq("b2b_second_data", 32'(rsp_rdata), 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
